// File: rtl/divider_control.sv
// Sequencing controller for the 32-bit restoring divider datapath: operand sign
// normalisation, one quotient bit per ITERATE cycle, sign fix-up, divide-by-zero and flush.
package divider2Pkg;
  typedef enum logic [1:0] {
    DIVIDEND_IN,
    NEG_DIVIDEND_IN,
    SHIFTED_DIVIDEND,
    NEG_DIVIDEND
  } dividendMux;

  typedef enum logic [1:0] {
    RESET_REMAINDER,
    SHIFTED_REMAINDER,
    TRIAL_REMAINDER,
    NEG_REMAINDER
  } remainderMux;

  typedef enum logic {
    DIVISOR_IN,
    NEG_DIVISOR_IN
  } divisorMux;
endpackage

module divider_control
  import divider2Pkg::*;
#(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        signedOp,
  input  logic        dividendMsb,
  input  logic        divisorMsb,
  input  logic        divisorZero,
  input  logic        trialNegative,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic        dividendEn,
  output dividendMux  dividendSel,
  output logic        fillerBit,
  output logic        remainderEn,
  output remainderMux remainderSel,
  output logic        divisorEn,
  output divisorMux   divisorSel
);

  typedef enum logic [1:0] {IDLE, ITERATE, FIXUP, DONE} state_t;

  localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);

  state_t     state;
  state_t     state_nx;
  logic [4:0] count;
  logic       negQuot;
  logic       negRem;
  logic       accept;

  assign accept = (state == IDLE) && start && !flush;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      negQuot   <= 1'b0;
      negRem    <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count     <= '0;
        negQuot   <= signedOp & (dividendMsb ^ divisorMsb);
        negRem    <= signedOp & dividendMsb;
        divByZero <= divisorZero;
      end else if (state == ITERATE) begin
        count <= count + 5'd1;
      end
    end
  end

  // Flush in any busy state overrides everything: back to IDLE with all enables low.
  always_comb begin
    state_nx     = state;
    dividendEn   = 1'b0;
    remainderEn  = 1'b0;
    divisorEn    = 1'b0;
    dividendSel  = DIVIDEND_IN;
    remainderSel = RESET_REMAINDER;
    divisorSel   = DIVISOR_IN;
    fillerBit    = 1'b0;

    if (flush && (state != IDLE)) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividendEn   = 1'b1;
            remainderEn  = 1'b1;
            divisorEn    = 1'b1;
            remainderSel = RESET_REMAINDER;
            // A zero divisor keeps the raw dividend so the quotient register reports it.
            dividendSel  = (signedOp && dividendMsb && !divisorZero) ? NEG_DIVIDEND_IN
                                                                     : DIVIDEND_IN;
            divisorSel   = (signedOp && divisorMsb) ? NEG_DIVISOR_IN : DIVISOR_IN;
            state_nx     = divisorZero ? DONE : ITERATE;
          end
        end

        ITERATE: begin
          dividendEn   = 1'b1;
          remainderEn  = 1'b1;
          dividendSel  = SHIFTED_DIVIDEND;
          fillerBit    = ~trialNegative;
          remainderSel = trialNegative ? SHIFTED_REMAINDER : TRIAL_REMAINDER;
          if (count == LAST_COUNT) begin
            state_nx = (negQuot || negRem) ? FIXUP : DONE;
          end
        end

        FIXUP: begin
          if (negQuot) begin
            dividendEn  = 1'b1;
            dividendSel = NEG_DIVIDEND;
          end
          if (negRem) begin
            remainderEn  = 1'b1;
            remainderSel = NEG_REMAINDER;
          end
          state_nx = DONE;
        end

        DONE: begin
          state_nx = IDLE;
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control: drives a behavioural divider datapath from the controller
// outputs and scoreboards quotient, remainder, divByZero and done timing against plain arithmetic.
module tb_divider_control;
  import divider2Pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        signedOp = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        dividendMsb;
  logic        divisorMsb;
  logic        divisorZero;
  logic        trialNegative;

  logic        busy;
  logic        done;
  logic        divByZero;
  logic        dividendEn;
  dividendMux  dividendSel;
  logic        fillerBit;
  logic        remainderEn;
  remainderMux remainderSel;
  logic        divisorEn;
  divisorMux   divisorSel;

  logic [31:0] dvd_r = '0;
  logic [31:0] rem_r = '0;
  logic [31:0] dsr_r = '0;
  logic [32:0] trial;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   end_cyc = -1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  assign dividendMsb   = a_in[31];
  assign divisorMsb    = b_in[31];
  assign divisorZero   = (b_in == 32'd0);
  assign trial         = {rem_r, dvd_r[31]} - {1'b0, dsr_r};
  assign trialNegative = ({rem_r, dvd_r[31]} < {1'b0, dsr_r});

  divider_control #(.ITERATIONS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .signedOp     (signedOp),
    .dividendMsb  (dividendMsb),
    .divisorMsb   (divisorMsb),
    .divisorZero  (divisorZero),
    .trialNegative(trialNegative),
    .busy         (busy),
    .done         (done),
    .divByZero    (divByZero),
    .dividendEn   (dividendEn),
    .dividendSel  (dividendSel),
    .fillerBit    (fillerBit),
    .remainderEn  (remainderEn),
    .remainderSel (remainderSel),
    .divisorEn    (divisorEn),
    .divisorSel   (divisorSel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath registers steered by the controller
  always @(posedge clk) begin
    if (dividendEn) begin
      case (dividendSel)
        DIVIDEND_IN:      dvd_r <= a_in;
        NEG_DIVIDEND_IN:  dvd_r <= -a_in;
        SHIFTED_DIVIDEND: dvd_r <= {dvd_r[30:0], fillerBit};
        default:          dvd_r <= -dvd_r;
      endcase
    end
    if (remainderEn) begin
      case (remainderSel)
        RESET_REMAINDER:   rem_r <= '0;
        SHIFTED_REMAINDER: rem_r <= {rem_r[30:0], dvd_r[31]};
        TRIAL_REMAINDER:   rem_r <= trial[31:0];
        default:           rem_r <= -rem_r;
      endcase
    end
    if (divisorEn) begin
      dsr_r <= (divisorSel == NEG_DIVISOR_IN) ? -b_in : b_in;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: magnitude division, then signs applied (quotient truncates toward zero).
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output exp_t e);
    logic        na, nb;
    logic [31:0] ma, mb, uq, ur;
    e.dbz = 1'b0;
    if (b == 32'd0) begin
      e.q = a;
      e.r = '0;
      e.dbz = 1'b1;
      e.done_cyc = 1;
    end else begin
      na = s & a[31];
      nb = s & b[31];
      ma = na ? (~a + 32'd1) : a;
      mb = nb ? (~b + 32'd1) : b;
      uq = ma / mb;
      ur = ma % mb;
      e.q = (na ^ nb) ? (~uq + 32'd1) : uq;
      e.r = na ? (~ur + 32'd1) : ur;
      e.done_cyc = (na | nb) ? 34 : 33;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc <= end_cyc) tick();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    wait_idle();
    a_in = a;
    b_in = b;
    signedOp = s;
    start = 1'b1;
    ref_div(a, b, s, e);
    e.done_cyc = cyc + e.done_cyc;
    sb.push_back(e);
    acc_cyc = cyc;
    end_cyc = e.done_cyc;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op(input bit allow_zero);
    case ($urandom_range(0, 7))
      0:       return allow_zero ? 32'd0 : 32'd1;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy window and done responses against the scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'((cyc > acc_cyc) && (cyc <= end_cyc)));
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, required done=0", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          chk("quotient", 64'(dvd_r), 64'(mon_e.q));
          chk("remainder", 64'(rem_r), 64'(mon_e.r));
          chk("divByZero", 64'(divByZero), 64'(mon_e.dbz));
        end
      end else if ((sb.size() > 0) && (cyc > sb[0].done_cyc)) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_done at cycle %0d: got done=0, required done=1 at cycle %0d",
                 cyc, sb[0].done_cyc);
        mon_e = sb.pop_front();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_divByZero", 64'(divByZero), 64'd0);
    chk("rst_dividendEn", 64'(dividendEn), 64'd0);
    chk("rst_remainderEn", 64'(remainderEn), 64'd0);
    chk("rst_divisorEn", 64'(divisorEn), 64'd0);
    chk("rst_dividendSel", 64'(dividendSel), 64'(DIVIDEND_IN));
    chk("rst_remainderSel", 64'(remainderSel), 64'(RESET_REMAINDER));
    chk("rst_divisorSel", 64'(divisorSel), 64'(DIVISOR_IN));
    chk("rst_fillerBit", 64'(fillerBit), 64'd0);
    chk_en = 1'b1;
    tick();

    issue(32'd100, 32'd7, 1'b0);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);
    issue(32'd100, 32'hFFFF_FFF9, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Divide by zero holds the flag until the next accept
    issue(32'h1234, 32'd0, 1'b0);
    wait_idle();
    repeat (3) tick();
    @(negedge clk);
    chk("dbz_hold", 64'(divByZero), 64'd1);
    tick();
    issue(32'd200, 32'd10, 1'b0);
    issue(32'hFFFF_0000, 32'd0, 1'b1);
    wait_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("dbz_reset", 64'(divByZero), 64'd0);
    tick();

    // Flush at cycle 10, restart on cycle 11
    issue(32'd50, 32'd5, 1'b0);
    a0 = acc_cyc;
    while (cyc < a0 + 10) tick();
    flush = 1'b1;
    sb.delete();
    end_cyc = cyc;
    @(negedge clk);
    chk("flush_dividendEn", 64'(dividendEn), 64'd0);
    chk("flush_remainderEn", 64'(remainderEn), 64'd0);
    chk("flush_divisorEn", 64'(divisorEn), 64'd0);
    tick();
    flush = 1'b0;
    issue(32'd9, 32'd2, 1'b0);

    // Start pulses at cycles 5 and 33 of an active divide are ignored
    issue(32'd1000, 32'd3, 1'b0);
    a0 = acc_cyc;
    while (cyc <= end_cyc) begin
      start = ((cyc - a0) == 5) || ((cyc - a0) == 33);
      a_in = $urandom;
      b_in = 32'($urandom_range(0, 3));
      signedOp = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    // Synchronous reset mid-operation
    issue(32'hDEAD_BEEF, 32'h0000_0123, 1'b1);
    a0 = acc_cyc;
    while (cyc < a0 + 20) tick();
    reset = 1'b1;
    sb.delete();
    end_cyc = cyc;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_dividendEn", 64'(dividendEn), 64'd0);
    chk("midrst_remainderEn", 64'(remainderEn), 64'd0);
    chk("midrst_divisorEn", 64'(divisorEn), 64'd0);
    tick();

    // Start together with flush in IDLE is not accepted
    wait_idle();
    a_in = 32'h42;
    b_in = 32'd0;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("blocked_dividendEn", 64'(dividendEn), 64'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("blocked_busy", 64'(busy), 64'd0);
    chk("blocked_done", 64'(done), 64'd0);
    tick();

    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(1'b0), rnd_op(1'b1), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_control.md
# divider_control

Sequencing controller for the 32-bit restoring divider datapath in the execute stage. Accepts a start request from the execute control, generates per-cycle enables and mux selects for the dividend/quotient, remainder and divisor registers, and drives the quotient filler bit. Handles signed-operand normalisation, the final sign fix-up, divide-by-zero and pipeline flush. Reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `ITERATIONS`, 32: quotient bits produced, one per ITERATE cycle.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a divide; accepted only in IDLE.
- `flush` in 1: abort any operation in progress.
- `signedOp` in 1: operands are two's complement. Sampled at accept.
- `dividendMsb` in 1: bit 31 of the incoming dividend.
- `divisorMsb` in 1: bit 31 of the incoming divisor.
- `divisorZero` in 1: incoming divisor equals 0.
- `trialNegative` in 1: sign of {remainder[30:0], dividend[31]} − divisor, computed by the datapath.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: single-cycle pulse; quotient and remainder registers are valid this cycle.
- `divByZero` out 1: registered; valid with `done`.
- `dividendEn` out 1: dividend register enable.
- `dividendSel` out `divider2Pkg::dividendMux`: dividend register next-value select.
- `fillerBit` out 1: quotient bit shifted into dividend[0].
- `remainderEn` out 1: remainder register enable.
- `remainderSel` out `divider2Pkg::remainderMux`: one of RESET_REMAINDER, SHIFTED_REMAINDER, TRIAL_REMAINDER, NEG_REMAINDER.
- `divisorEn` out 1: divisor register enable.
- `divisorSel` out `divider2Pkg::divisorMux`: one of DIVISOR_IN, NEG_DIVISOR_IN.

## Operation
States: IDLE, ITERATE, FIXUP, DONE. Internal registers:
- 5-bit iteration counter.
- `negQuot`, `negRem` sign flags.
- `divByZero`.

Default outputs:
- All enables 0.
- `dividendSel` = DIVIDEND_IN, `remainderSel` = RESET_REMAINDER, `divisorSel` = DIVISOR_IN, `fillerBit` = 0.

IDLE, when `start` is high and `flush` is low (accept):
- `dividendEn` = `remainderEn` = `divisorEn` = 1.
- `remainderSel` = RESET_REMAINDER.
- `dividendSel` = NEG_DIVIDEND_IN if `signedOp` and `dividendMsb`, else DIVIDEND_IN.
- `divisorSel` = NEG_DIVISOR_IN if `signedOp` and `divisorMsb`, else DIVISOR_IN.
- Latch `negQuot` = signedOp & (dividendMsb ^ divisorMsb) and `negRem` = signedOp & dividendMsb.
- Clear the counter. Latch `divByZero` = `divisorZero`.
- If `divisorZero`: `dividendSel` = DIVIDEND_IN regardless of sign, and go to DONE.
- Otherwise go to ITERATE.

ITERATE:
- `dividendEn` = `remainderEn` = 1.
- `dividendSel` = SHIFTED_DIVIDEND, `fillerBit` = ~`trialNegative`.
- `remainderSel` = SHIFTED_REMAINDER if `trialNegative`, else TRIAL_REMAINDER.
- Counter increments each cycle.
- Leave after the cycle with counter = ITERATIONS−1: go to FIXUP if `negQuot` | `negRem`, else go to DONE.

FIXUP (one cycle, both fix-ups in parallel):
- If `negQuot`: `dividendEn` = 1, `dividendSel` = NEG_DIVIDEND.
- If `negRem`: `remainderEn` = 1, `remainderSel` = NEG_REMAINDER.
- Go to DONE.

DONE:
- `done` = 1, no enables.
- Go to IDLE. A `start` in DONE is ignored.

`flush`:
- In any non-IDLE state, the next state is IDLE, all enables are 0 that cycle, and `done` is not pulsed.
- In IDLE, `flush` blocks acceptance of a simultaneous `start`.

`start` while `busy`: ignored, with no effect on state or flags.

Divide by zero:
- Quotient register holds the raw dividend and remainder is 0.
- `divByZero` stays high until the next accept.

Signed overflow (0x80000000 / −1): no special case. Two's-complement wrap yields quotient 0x80000000 and remainder 0.

## Timing
- Reset values: state IDLE, counter 0, `negQuot` = `negRem` = `divByZero` = 0, `busy` = `done` = 0, all enables 0, selects at their defaults.
- `reset` mid-operation returns to IDLE on the next edge with no `done`. Datapath contents are left stale.
- Latency, counted from the accept edge (cycle 0):
  - ITERATE occupies cycles 1–32.
  - `done` in cycle 33 for unsigned/positive results, or cycle 34 when FIXUP runs.
  - `done` in cycle 1 for divide by zero.
- `busy` is high from cycle 1 through the `done` cycle. The earliest next accept is the cycle after `done`.
- All outputs except `busy`, `done` and `divByZero` are combinational from state, the counter, the latched flags and the current inputs.

## Test plan
- Unsigned 100 / 7, `signedOp` = 0 → `done` at cycle 33; quotient register 14, remainder 2, `divByZero` 0.
- Signed −100 / 7 → FIXUP runs, `done` at cycle 34; quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). Signed 100 / −7 → quotient −14, remainder 2.
- Divide by zero: 0x1234 / 0 → `done` at cycle 1, `divByZero` 1, quotient register 0x1234, remainder 0. The next accepted start clears `divByZero`.
- Flush at cycle 10 of 50 / 5 → IDLE at cycle 11 with no `done`. A new start 9 / 2 at cycle 11 → quotient 4, remainder 1, `done` 33 cycles later.
- `start` pulsed at cycles 5 and 33 of an active divide → both ignored; exactly one `done`, results unchanged.
- Synchronous reset asserted at cycle 20 → `busy` = 0 and all enables 0 from cycle 21, no `done`. Start in IDLE together with `flush` → not accepted.
